port_arbiter: RTL and testbench

PORT_ARBITER -- requirements
Module: port_arbiter

---
 rtl/switch_pkg.sv | 6 +
 rtl/rr_picker.sv | 21 ++
 rtl/port_arbiter.sv | 103 ++++++++++
 tb/tb_port_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// switch_pkg: shared switch types and sizes for the output-port arbiters
package switch_pkg;
    localparam int NUM_PORTS  = 4;
    localparam int PORT_IDX_W = 2;
    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: rotate-priority encoder, first requester at or after ptr wins
module rr_picker
    import switch_pkg::*;
(
    input  logic [NUM_PORTS-1:0]  req_i,
    input  logic [PORT_IDX_W-1:0] ptr_i,
    output logic [PORT_IDX_W-1:0] winner_o,
    output logic                  found_o
);
    logic [PORT_IDX_W-1:0] idx;
    // Walk from the farthest offset back to ptr so the nearest requester overwrites last
    always_comb begin
        winner_o = '0;
        idx = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = ptr_i + PORT_IDX_W'(k);
            if (req_i[idx]) winner_o = idx;
        end
    end
    assign found_o = |req_i;
endmodule

// File: rtl/port_arbiter.sv
// port_arbiter: round-robin arbiter granting one input port to output PORT_ID.
// Define PORT_ARB_TIMEOUT_EN to add a watchdog revoking grants held TIMEOUT cycles.
module port_arbiter
    import switch_pkg::*;
#(
    parameter int PORT_ID = 0,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_PORTS-1:0]  req_valid,
    input  logic [NUM_PORTS-1:0]  pkt_dst0,
    input  logic [NUM_PORTS-1:0]  pkt_dst1,
    input  logic [NUM_PORTS-1:0]  pkt_dst2,
    input  logic [NUM_PORTS-1:0]  pkt_dst3,
    input  logic [NUM_PORTS-1:0]  done,
    output logic [NUM_PORTS-1:0]  grant,
    output logic                  arb_active,
    output logic [PORT_IDX_W-1:0] mux_select,
    output logic                  timeout_err
);
    localparam logic [PORT_IDX_W-1:0] DST_BIT = PORT_IDX_W'(PORT_ID);

    if (PORT_ID < 0 || PORT_ID >= NUM_PORTS || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_cfg
        $error("port_arbiter: PORT_ID or TIMEOUT out of range");
    end

    arb_state_t            state_q;
    logic [NUM_PORTS-1:0]  grant_q;
    logic                  active_q;
    logic [PORT_IDX_W-1:0] mux_q;
    logic [PORT_IDX_W-1:0] ptr_q;
    logic [NUM_PORTS-1:0]  req;
    logic [PORT_IDX_W-1:0] winner;
    logic                  found;
    logic                  released;
    logic                  expire;
    logic                  dst_unused;

    assign req = req_valid & {pkt_dst3[DST_BIT], pkt_dst2[DST_BIT], pkt_dst1[DST_BIT], pkt_dst0[DST_BIT]};
    assign dst_unused = ^{pkt_dst0, pkt_dst1, pkt_dst2, pkt_dst3};
    // Withdraw or destination change of the holder counts the same as done
    assign released = done[mux_q] | ~req[mux_q];

    rr_picker u_picker (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .winner_o (winner),
        .found_o  (found)
    );

`ifdef PORT_ARB_TIMEOUT_EN
    logic [7:0] hold_q;
    logic       terr_q;
    assign expire      = hold_q == 8'(TIMEOUT - 1);
    assign timeout_err = terr_q;
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            active_q <= 1'b0;
            mux_q    <= '0;
            ptr_q    <= '0;
`ifdef PORT_ARB_TIMEOUT_EN
            hold_q   <= '0;
            terr_q   <= 1'b0;
`endif
        end else if (state_q == ARB_IDLE) begin
`ifdef PORT_ARB_TIMEOUT_EN
            terr_q <= 1'b0;
`endif
            if (found) begin
                state_q  <= ARB_GRANT;
                grant_q  <= NUM_PORTS'(1) << winner;
                active_q <= 1'b1;
                mux_q    <= winner;
`ifdef PORT_ARB_TIMEOUT_EN
                hold_q   <= '0;
`endif
            end
        end else if (released || expire) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            active_q <= 1'b0;
            ptr_q    <= mux_q + PORT_IDX_W'(1);
`ifdef PORT_ARB_TIMEOUT_EN
            terr_q   <= ~released;
`endif
        end
`ifdef PORT_ARB_TIMEOUT_EN
        else hold_q <= hold_q + 8'd1;
`endif
    end

    assign grant      = grant_q;
    assign arb_active = active_q;
    assign mux_select = mux_q;
endmodule

// File: tb/tb_port_arbiter.sv
// tb_port_arbiter: directed and random checks of two arbiter instances (PORT_ID 0 and 2)
module tb_port_arbiter;
    localparam int TMO = 15;
`ifdef PORT_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_valid = '0;
    logic [3:0] dst [4];
    logic [3:0] done = '0;
    logic [3:0] g0, g2;
    logic       a0, a2, t0, t2;
    logic [1:0] m0, m2;
    int n_checks = 0;
    int n_fail = 0;
    int m_own [2];
    int m_ptr [2];
    int m_mux [2];
    int m_held [2];
    bit m_terr [2];
    int pid [2] = '{0, 2};

    always #5 clk = ~clk;

    port_arbiter #(.PORT_ID(0), .TIMEOUT(TMO)) u0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
        .pkt_dst0(dst[0]), .pkt_dst1(dst[1]), .pkt_dst2(dst[2]), .pkt_dst3(dst[3]),
        .done(done), .grant(g0), .arb_active(a0), .mux_select(m0), .timeout_err(t0)
    );
    port_arbiter #(.PORT_ID(2), .TIMEOUT(TMO)) u2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
        .pkt_dst0(dst[0]), .pkt_dst1(dst[1]), .pkt_dst2(dst[2]), .pkt_dst3(dst[3]),
        .done(done), .grant(g2), .arb_active(a2), .mux_select(m2), .timeout_err(t2)
    );

    // Reference: owner index (-1 idle), pointer, grant-cycle count held so far
    function automatic void step(input int own, input int ptr, input int mux, input int held,
                                 input logic [3:0] r, input logic [3:0] d,
                                 output int no, output int np, output int nm, output int nh, output bit nt);
        no = own; np = ptr; nm = mux; nh = held; nt = 1'b0;
        if (own < 0) begin
            for (int j = 0; j < 4; j++)
                if (no < 0 && r[(ptr + j) % 4]) begin
                    no = (ptr + j) % 4; nm = no; nh = 1;
                end
        end else if (d[own] || !r[own] || (TO_EN && held >= TMO)) begin
            nt = !(d[own] || !r[own]);
            no = -1;
            np = (own + 1) % 4;
        end else nh = held + 1;
    endfunction

    function automatic logic [3:0] eff_req(input int p);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = req_valid[i] && dst[i][p];
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int no, np, nm, nh;
        bit nt;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_own[k] <= -1; m_ptr[k] <= 0; m_mux[k] <= 0; m_held[k] <= 0; m_terr[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                step(m_own[k], m_ptr[k], m_mux[k], m_held[k], eff_req(pid[k]), done, no, np, nm, nh, nt);
                m_own[k] <= no; m_ptr[k] <= np; m_mux[k] <= nm; m_held[k] <= nh; m_terr[k] <= nt;
            end
        end
    end

    function automatic logic [7:0] exp_out(input int k);
        logic [3:0] g;
        g = (m_own[k] < 0) ? 4'b0000 : 4'(1 << m_own[k]);
        return {g, m_own[k] >= 0, 2'(m_mux[k]), m_terr[k]};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0; done = '0;
        for (int i = 0; i < 4; i++) dst[i] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({g0, a0, m0, t0} !== 8'h00) begin n_fail++; $display("FAIL reset_u0: got %h expected 00", {g0, a0, m0, t0}); end
        n_checks++;
        if ({g2, a2, m2, t2} !== 8'h00) begin n_fail++; $display("FAIL reset_u2: got %h expected 00", {g2, a2, m2, t2}); end
        do_reset();
        @(negedge clk);
        n_checks++;
        if ({g0, a0, g2, a2} !== 10'h000) begin n_fail++; $display("FAIL idle_after_reset: got %h expected 000", {g0, a0, g2, a2}); end
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0010; dst[1] = 4'b0100;
        @(negedge clk);
        n_checks++;
        if ({g2, a2, m2} !== {4'b0010, 1'b1, 2'd1}) begin n_fail++; $display("FAIL single_grant: got %h expected %h", {g2, a2, m2}, {4'b0010, 1'b1, 2'd1}); end
        n_checks++;
        if (g0 !== 4'b0000) begin n_fail++; $display("FAIL single_other_inst: got %b expected 0000", g0); end
        done = 4'b0010;
        @(negedge clk);
        n_checks++;
        if ({g2, a2, m2} !== {4'b0000, 1'b0, 2'd1}) begin n_fail++; $display("FAIL single_release: got %h expected %h", {g2, a2, m2}, {4'b0000, 1'b0, 2'd1}); end
        done = '0; req_valid = 4'b0110; dst[2] = 4'b0100;
        @(negedge clk);
        n_checks++;
        if (g2 !== 4'b0100) begin n_fail++; $display("FAIL single_ptr_next: got %b expected 0100", g2); end
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < 4; i++) dst[i] = 4'b0001;
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (g0 !== 4'(1 << order[i])) begin n_fail++; $display("FAIL rr_grant_%0d: got %b expected %b", i, g0, 4'(1 << order[i])); end
            done = 4'(1 << order[i]);
            @(negedge clk);
            done = '0;
            n_checks++;
            if ({g0, a0} !== 5'b0) begin n_fail++; $display("FAIL rr_idle_gap_%0d: got %h expected 00", i, {g0, a0}); end
        end
    endtask

    task automatic test_dst_change();
        do_reset();
        req_valid = 4'b1000; dst[3] = 4'b0100;
        @(negedge clk);
        n_checks++;
        if (g2 !== 4'b1000) begin n_fail++; $display("FAIL dst_grant: got %b expected 1000", g2); end
        dst[3] = 4'b0001;
        @(negedge clk);
        n_checks++;
        if ({g2, a2, t2} !== 6'b0) begin n_fail++; $display("FAIL dst_release: got %h expected 00", {g2, a2, t2}); end
        req_valid = 4'b1001; dst[3] = 4'b0100; dst[0] = 4'b0100;
        @(negedge clk);
        n_checks++;
        if (g2 !== 4'b0001) begin n_fail++; $display("FAIL dst_ptr_wrap: got %b expected 0001", g2); end
    endtask

    task automatic test_nonwinner_done();
        do_reset();
        req_valid = 4'b0010; dst[1] = 4'b0100;
        @(negedge clk);
        req_valid = 4'b0110; dst[2] = 4'b0100; done = 4'b0100;
        @(negedge clk);
        done = '0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({g2, a2, m2} !== {4'b0010, 1'b1, 2'd1}) begin n_fail++; $display("FAIL nonwinner_hold_%0d: got %h expected %h", i, {g2, a2, m2}, {4'b0010, 1'b1, 2'd1}); end
            @(negedge clk);
        end
    endtask

    task automatic test_hold_limit();
        do_reset();
        dst[0] = 4'b0001; dst[1] = 4'b0001; req_valid = 4'b0011;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            n_checks++;
            if ({g0, t0} !== 5'b00010) begin n_fail++; $display("FAIL hold_cycle_%0d: got %h expected 02", i, {g0, t0}); end
        end
        @(negedge clk);
        if (TO_EN) begin
            n_checks++;
            if ({g0, a0, t0} !== 6'b000001) begin n_fail++; $display("FAIL timeout_revoke: got %b expected 000001", {g0, a0, t0}); end
            @(negedge clk);
            n_checks++;
            if ({g0, t0} !== 5'b00100) begin n_fail++; $display("FAIL timeout_next: got %b expected 00100", {g0, t0}); end
        end else begin
            repeat (4) @(negedge clk);
            n_checks++;
            if ({g0, t0} !== 5'b00010) begin n_fail++; $display("FAIL no_watchdog_hold: got %b expected 00010", {g0, t0}); end
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req_valid = 4'b0100; dst[2] = 4'b0100;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({g2, a2} !== 5'b0) begin n_fail++; $display("FAIL async_reset_drop: got %b expected 00000", {g2, a2}); end
        @(negedge clk);
        rst_n = 1'b1; req_valid = 4'b0101; dst[0] = 4'b0100;
        @(negedge clk);
        n_checks++;
        if (g2 !== 4'b0001) begin n_fail++; $display("FAIL reset_ptr_zero: got %b expected 0001", g2); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) req_valid = 4'($urandom);
            if ($urandom_range(0, 5) == 0) dst[$urandom_range(0, 3)] = 4'($urandom);
            done = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
            @(negedge clk);
            n_checks++;
            if ({g0, a0, m0, t0} !== exp_out(0)) begin n_fail++; $display("FAIL random_u0 cyc %0d: got %h expected %h", c, {g0, a0, m0, t0}, exp_out(0)); end
            n_checks++;
            if ({g2, a2, m2, t2} !== exp_out(1)) begin n_fail++; $display("FAIL random_u2 cyc %0d: got %h expected %h", c, {g2, a2, m2, t2}, exp_out(1)); end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) dst[i] = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_dst_change();
        test_nonwinner_done();
        test_hold_limit();
        test_reset_mid_grant();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
